pc_fetch_btb: RTL and testbench

Parametrised instruction-fetch front end for the 5-stage MIPS pipeline: owns the PC register, instruction-memory request, and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts next PC in IF, replacing the fixed "PC+4 until MEM resolves" scheme.
- Accepts branch resolution from MEM, trains the BTB, and redirects fetch on misprediction.

---
 rtl/pc_fetch_btb_if.sv | 39 +++
 rtl/pc_fetch_btb.sv | 118 +++++++++++
 tb/tb_pc_fetch_btb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_btb_if.sv
// Fetch/resolution bus between the PC/BTB front end and the pipeline.
// FETCH_STATS_EN adds the branch/mispredict statistic counters to the bus.
interface pc_fetch_btb_if #(parameter int ADDR_W = 32);
    logic              if_en;
    logic              inst_ren;
    logic [ADDR_W-1:0] inst_addr;
    logic              pred_taken_if;
    logic [ADDR_W-1:0] pred_target_if;
    logic              res_valid;
    logic [ADDR_W-1:0] res_pc;
    logic              res_is_branch;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              res_pred_taken;
    logic [ADDR_W-1:0] res_pred_target;
    logic              redirect;
`ifdef FETCH_STATS_EN
    logic [31:0]       stat_branch;
    logic [31:0]       stat_mispredict;
`endif

    // master = fetch block, slave = pipeline/control side
    modport master (
        input  if_en, res_valid, res_pc, res_is_branch, res_taken, res_target,
               res_pred_taken, res_pred_target,
`ifdef FETCH_STATS_EN
        output stat_branch, stat_mispredict,
`endif
        output inst_ren, inst_addr, pred_taken_if, pred_target_if, redirect
    );
    modport slave (
        output if_en, res_valid, res_pc, res_is_branch, res_taken, res_target,
               res_pred_taken, res_pred_target,
`ifdef FETCH_STATS_EN
        input  stat_branch, stat_mispredict,
`endif
        input  inst_ren, inst_addr, pred_taken_if, pred_target_if, redirect
    );
endinterface

// File: rtl/pc_fetch_btb.sv
// Fetch front end: PC register plus direct-mapped BTB with 2-bit counters.
// Optional FETCH_STATS_EN adds saturating branch/mispredict counters.
module pc_fetch_btb #(
    parameter int              ADDR_W    = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_btb_if.master    bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];
    logic [1:0]           cnt_q [BTB_DEPTH];

    // Lookup side
    logic [IDX_W-1:0]  l_idx;
    logic [TAG_W-1:0]  l_tag;
    logic              l_hit;
    logic [ADDR_W-1:0] pc_plus4;

    assign l_idx    = pc_q[IDX_W+1:2];
    assign l_tag    = pc_q[ADDR_W-1:IDX_W+2];
    assign l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pc_plus4 = pc_q + ADDR_W'(4);

    assign bus.inst_ren       = rst_n;
    assign bus.inst_addr      = pc_q;
    assign bus.pred_taken_if  = l_hit && cnt_q[l_idx][1];
    assign bus.pred_target_if = l_hit ? tgt_q[l_idx] : pc_plus4;

    // Resolution side
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit, mispredict, redirect;
    logic [ADDR_W-1:0] correct_pc;
    logic              upd_alloc, upd_train, upd_inval;

    assign r_idx = bus.res_pc[IDX_W+1:2];
    assign r_tag = bus.res_pc[ADDR_W-1:IDX_W+2];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign mispredict = bus.res_is_branch
        ? ((bus.res_taken != bus.res_pred_taken) ||
           (bus.res_taken && (bus.res_target != bus.res_pred_target)))
        : bus.res_pred_taken;
    assign redirect     = bus.res_valid && mispredict;
    assign bus.redirect = redirect;
    assign correct_pc   = (bus.res_is_branch && bus.res_taken) ? bus.res_target
                                                               : bus.res_pc + ADDR_W'(4);

    assign upd_alloc = bus.res_valid &&  bus.res_is_branch && !r_hit && bus.res_taken;
    assign upd_train = bus.res_valid &&  bus.res_is_branch &&  r_hit;
    assign upd_inval = bus.res_valid && !bus.res_is_branch &&  r_hit;

    always_comb begin
        pc_d = pc_q;
        if (redirect)
            pc_d = correct_pc;
        else if (bus.if_en)
            pc_d = bus.pred_taken_if ? bus.pred_target_if : pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (upd_alloc)
                valid_q[r_idx] <= 1'b1;
            else if (upd_inval)
                valid_q[r_idx] <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed through valid_q.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (upd_alloc) begin
                tag_q[r_idx] <= r_tag;
                tgt_q[r_idx] <= bus.res_target;
                cnt_q[r_idx] <= 2'b10;
            end else if (upd_train) begin
                if (bus.res_taken) begin
                    tgt_q[r_idx] <= bus.res_target;
                    if (cnt_q[r_idx] != 2'b11) cnt_q[r_idx] <= cnt_q[r_idx] + 2'd1;
                end else if (cnt_q[r_idx] != 2'b00) begin
                    cnt_q[r_idx] <= cnt_q[r_idx] - 2'd1;
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (bus.res_valid && bus.res_is_branch && (stat_br_q != '1))
                stat_br_q <= stat_br_q + 32'd1;
            if (redirect && (stat_mp_q != '1))
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign bus.stat_branch     = stat_br_q;
    assign bus.stat_mispredict = stat_mp_q;
`endif
endmodule

// File: tb/tb_pc_fetch_btb.sv
// Directed table-driven bench for pc_fetch_btb (ADDR_W=32, BTB_DEPTH=16, RESET_PC=0).
module tb_pc_fetch_btb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_btb_if #(.ADDR_W(32)) bus ();
    pc_fetch_btb #(.ADDR_W(32), .BTB_DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );

    typedef struct {
        logic        if_en;
        logic        rv;
        logic [31:0] rpc;
        logic        rbr;
        logic        rtk;
        logic [31:0] rtgt;
        logic        rptk;
        logic [31:0] rptgt;
        logic [31:0] e_addr;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_redir;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [$];

    function automatic vec_t mk(logic en, logic rv, logic [31:0] rpc, logic rbr, logic rtk,
                                logic [31:0] rtgt, logic rptk, logic [31:0] rptgt,
                                logic [31:0] ea, logic ep, logic [31:0] et, logic er);
        vec_t v;
        v.if_en = en; v.rv = rv; v.rpc = rpc; v.rbr = rbr; v.rtk = rtk; v.rtgt = rtgt;
        v.rptk = rptk; v.rptgt = rptgt; v.e_addr = ea; v.e_ptk = ep; v.e_ptgt = et;
        v.e_redir = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.if_en = v.if_en; bus.res_valid = v.rv; bus.res_pc = v.rpc;
        bus.res_is_branch = v.rbr; bus.res_taken = v.rtk; bus.res_target = v.rtgt;
        bus.res_pred_taken = v.rptk; bus.res_pred_target = v.rptgt;
    endtask

    task automatic check_vec(string tag, vec_t v);
        chk({tag, ".inst_addr"},      bus.inst_addr,            v.e_addr);
        chk({tag, ".pred_taken_if"},  32'(bus.pred_taken_if),   32'(v.e_ptk));
        chk({tag, ".pred_target_if"}, bus.pred_target_if,       v.e_ptgt);
        chk({tag, ".redirect"},       32'(bus.redirect),        32'(v.e_redir));
    endtask

    initial begin
        //        en rv rpc        br tk tgt          ptk ptgt       addr         ptk ptgt       redir
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h0,        0,32'h4,       0)); // 0 sequential
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h4,        0,32'h8,       0));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h8,        0,32'hC,       0));
        tbl.push_back(mk(1,1,32'h10,   1,1,32'h40,      0,32'h14,   32'hC,        0,32'h10,      1)); // 3 alloc 0x10->0x40
        tbl.push_back(mk(0,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h40,       0,32'h44,      0)); // 4 stall
        tbl.push_back(mk(0,1,32'h60,   0,0,32'h0,       0,32'h0,    32'h40,       0,32'h44,      0)); // 5 non-branch, no hit
        tbl.push_back(mk(0,1,32'h20,   1,1,32'h10,      0,32'h24,   32'h40,       0,32'h44,      1)); // 6 redirect under stall
        tbl.push_back(mk(1,1,32'h10,   1,0,32'h0,       1,32'h40,   32'h10,       1,32'h40,      1)); // 7 predicted, resolves NT
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h14,       0,32'h18,      0));
        tbl.push_back(mk(1,1,32'h10,   1,0,32'h0,       0,32'h40,   32'h18,       0,32'h1C,      0)); // 9 cnt 01->00
        tbl.push_back(mk(0,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h1C,       0,32'h20,      0)); // 10..12 hold
        tbl.push_back(mk(0,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h1C,       0,32'h20,      0));
        tbl.push_back(mk(0,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h1C,       0,32'h20,      0));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h1C,       0,32'h20,      0));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h20,       1,32'h10,      0)); // 14 taken, 0 penalty
        tbl.push_back(mk(1,1,32'h50,   1,1,32'h90,      0,32'h54,   32'h10,       0,32'h40,      1)); // 15 hit NT; alias alloc 0x50
        tbl.push_back(mk(1,1,32'hC,    0,0,32'h0,       1,32'h0,    32'h90,       0,32'h94,      1)); // 16 non-branch mispredict
        tbl.push_back(mk(1,1,32'h4C,   0,0,32'h0,       1,32'h0,    32'h10,       0,32'h14,      1)); // 17 0x10 evicted
        tbl.push_back(mk(1,1,32'h20,   0,0,32'h0,       0,32'h0,    32'h50,       1,32'h90,      0)); // 18 0x50 hits; inval idx 8
        tbl.push_back(mk(1,1,32'h1C,   0,0,32'h0,       1,32'h0,    32'h90,       0,32'h94,      1));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h20,       0,32'h24,      0)); // 20 invalidated
        tbl.push_back(mk(1,1,32'h100,  1,1,32'hFFFF_FFFC,0,32'h104, 32'h24,       0,32'h28,      1));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'hFFFF_FFFC,0,32'h0,       0)); // 22 wrap
        tbl.push_back(mk(1,1,32'h50,   1,1,32'hA0,      1,32'h90,   32'h0,        0,32'h4,       1)); // 23 wrong target
        tbl.push_back(mk(1,1,32'h4C,   0,0,32'h0,       1,32'h0,    32'hA0,       0,32'hA4,      1));
        tbl.push_back(mk(1,0,32'h0,    0,0,32'h0,       0,32'h0,    32'h50,       1,32'hA0,      0)); // 25 retrained target
        tbl.push_back(mk(0,0,32'h0,    0,0,32'h0,       0,32'h0,    32'hA0,       0,32'hA4,      0));

        drive(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        chk("rst.inst_ren",       32'(bus.inst_ren),       32'h0);
        chk("rst.inst_addr",      bus.inst_addr,           32'h0);
        chk("rst.pred_taken_if",  32'(bus.pred_taken_if),  32'h0);
        chk("rst.pred_target_if", bus.pred_target_if,      32'h4);
        rst_n = 1'b1;
        #1 chk("run.inst_ren",    32'(bus.inst_ren),       32'h1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i]);
            #1 check_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Mid-stream async reset: PC and valid bits clear without waiting for an edge.
        @(negedge clk);
        drive(mk(1,1,32'h50,1,1,32'h200,0,32'h0,0,0,0,0));
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.inst_addr",      bus.inst_addr,          32'h0);
        chk("mrst.inst_ren",       32'(bus.inst_ren),      32'h0);
        chk("mrst.pred_target_if", bus.pred_target_if,     32'h4);
`ifdef FETCH_STATS_EN
        chk("mrst.stat_branch",     bus.stat_branch,       32'h0);
        chk("mrst.stat_mispredict", bus.stat_mispredict,   32'h0);
`endif
        @(negedge clk);
        drive(mk(1,1,32'h4C,0,0,0,1,0,0,0,0,0));
        rst_n = 1'b1;
        #1 chk("post.redirect", 32'(bus.redirect), 32'h1);
        @(negedge clk);
        drive(mk(1,0,32'h4C,0,0,0,1,0,0,0,0,0));
        #1;
        chk("post.redirect_idle",  32'(bus.redirect),      32'h0);
        chk("post.inst_addr",      bus.inst_addr,          32'h50);
        chk("post.pred_taken_if",  32'(bus.pred_taken_if), 32'h0);
        chk("post.pred_target_if", bus.pred_target_if,     32'h54);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
